mux_scan_seq: RTL and testbench

//  Upstream sequencer for the 4:1 x W-bit data mux. Drives the mux select, waits for the mux output to settle,

---
 rtl/mux_scan_pkg.sv | 32 +++
 rtl/mux_scan_pick.sv | 36 +++
 rtl/mux_scan_seq.sv | 151 +++++++++++++++
 tb/tb_mux_scan_seq.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared types, constants and channel search helper for the mux scan sequencer
//
// Purpose: state encoding, channel/select widths and the "next enabled channel above cur"
//          search used by mux_scan_pick and mux_scan_seq.
// Ports:   none (package).
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SEND
  } state_t;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 3;   // holds the settle count, 0..7

  // Returns {found, idx}: the lowest set bit of mask strictly above cur.
  // Scanning downward lets the last hit be the lowest qualifying index.
  function automatic logic [SEL_W:0] next_ch(input logic [N_CH-1:0] mask,
                                             input logic [SEL_W-1:0] cur);
    logic [SEL_W:0] r;
    r = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        r = {1'b1, SEL_W'(i)};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_scan_pick.sv
// rtl/mux_scan_pick.sv - combinational channel finder for scan start and scan advance
//
// Purpose: finds the lowest enabled channel of a fresh mask (scan start) and the next
//          enabled channel above the current select in the latched mask (advance).
// Ports:
//   first_mask  in   4  mask used at scan start (live ChEn)
//   next_mask   in   4  mask latched for the scan in progress
//   cur         in   2  current select
//   first_idx   out  2  lowest set bit of first_mask (0 when the mask is empty)
//   next_found  out  1  a set bit exists in next_mask above cur
//   next_idx    out  2  index of that bit
module mux_scan_pick
  import mux_scan_pkg::*;
(
  input  logic [N_CH-1:0]  first_mask,
  input  logic [N_CH-1:0]  next_mask,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] first_idx,
  output logic             next_found,
  output logic [SEL_W-1:0] next_idx
);

  always_comb begin
    first_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (first_mask[i]) begin
        first_idx = SEL_W'(i);
      end
    end
  end

  always_comb begin
    {next_found, next_idx} = next_ch(next_mask, cur);
  end

endmodule

// File: rtl/mux_scan_seq.sv
// rtl/mux_scan_seq.sv - scan sequencer serializing four mux channels onto a valid/ready stream
//
// Purpose: steps the 4:1 mux select over the enabled channels in ascending order, waits
//          SETTLE_CYCLES for the mux output, samples it and emits one {channel, data} beat.
// Optional feature: define MUX_SCAN_CHANGE_ONLY_EN to suppress beats whose data equals the
//          last value sent on that channel.
// Ports:
//   Clk         in   1  clock, rising edge
//   Rst_n       in   1  asynchronous active-low reset
//   Start       in   1  start a scan (honoured only in IDLE with ChEn != 0)
//   Continuous  in   1  chain a new scan at the end of the current one
//   ChEn        in   4  channel enable mask, latched at scan start
//   Sel         out  2  registered mux select
//   Yin         in   W  mux output
//   OutValid    out  1  beat valid
//   OutReady    in   1  beat accepted
//   OutCh       out  2  beat channel
//   OutData     out  W  beat data
//   Busy        out  1  state != IDLE
//   ScanDone    out  1  one-cycle pulse at the end of each scan
module mux_scan_seq
  import mux_scan_pkg::*;
#(
  parameter int W             = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             Continuous,
  input  logic [N_CH-1:0]  ChEn,
  output logic [SEL_W-1:0] Sel,
  input  logic [W-1:0]     Yin,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [SEL_W-1:0] OutCh,
  output logic [W-1:0]     OutData,
  output logic             Busy,
  output logic             ScanDone
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);

  state_t           state;
  logic [N_CH-1:0]  mask;
  logic [CNT_W-1:0] cnt;

  logic [SEL_W-1:0] first_idx;
  logic [SEL_W-1:0] next_idx;
  logic             next_found;
  logic             sample;
  logic             skip;
  logic             advance;

  mux_scan_pick u_pick (
    .first_mask (ChEn),
    .next_mask  (mask),
    .cur        (Sel),
    .first_idx  (first_idx),
    .next_found (next_found),
    .next_idx   (next_idx)
  );

  assign sample = (state == SETTLE) && (cnt == '0);

`ifdef MUX_SCAN_CHANGE_ONLY_EN
  logic [W-1:0]    last_data [N_CH];
  logic [N_CH-1:0] seen;

  // An unchanged channel is treated as if its beat had already been accepted.
  assign skip = seen[Sel] && (Yin == last_data[Sel]);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      seen <= '0;
      for (int i = 0; i < N_CH; i++) begin
        last_data[i] <= '0;
      end
    end else if (sample && !skip) begin
      seen[Sel]      <= 1'b1;
      last_data[Sel] <= Yin;
    end
  end
`else
  assign skip = 1'b0;
`endif

  // OutValid is high throughout SEND, so the handshake reduces to SEND && OutReady.
  assign advance = ((state == SEND) && OutReady) || (sample && skip);
  assign Busy    = (state != IDLE);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      Sel      <= '0;
      OutValid <= 1'b0;
      OutCh    <= '0;
      OutData  <= '0;
      ScanDone <= 1'b0;
      mask     <= '0;
      cnt      <= '0;
    end else begin
      ScanDone <= 1'b0;
      if (advance) begin
        OutValid <= 1'b0;
        if (next_found) begin
          Sel   <= next_idx;
          cnt   <= SETTLE_LD;
          state <= SETTLE;
        end else begin
          ScanDone <= 1'b1;
          if (Continuous && (ChEn != '0)) begin
            mask  <= ChEn;
            Sel   <= first_idx;
            cnt   <= SETTLE_LD;
            state <= SETTLE;
          end else begin
            // Sel deliberately keeps the last channel visited.
            state <= IDLE;
          end
        end
      end else begin
        case (state)
          IDLE: begin
            if (Start && (ChEn != '0)) begin
              mask  <= ChEn;
              Sel   <= first_idx;
              cnt   <= SETTLE_LD;
              state <= SETTLE;
            end
          end
          SETTLE: begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else begin
              OutData  <= Yin;
              OutCh    <= Sel;
              OutValid <= 1'b1;
              state    <= SEND;
            end
          end
          SEND: begin
            // Beat holds until the consumer takes it.
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_seq.sv
// tb/tb_mux_scan_seq.sv - self-checking bench for mux_scan_seq with a behavioural mux and scan model
module tb_mux_scan_seq;

  localparam int W = 4;
  localparam int S = 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         continuous;
  logic [3:0]   chen;
  logic [1:0]   sel;
  logic [W-1:0] yin;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_ch;
  logic [W-1:0] out_data;
  logic         busy;
  logic         scan_done;

  logic [W-1:0] d [4];

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int b_ch [$];
  int b_d  [$];
  int b_t  [$];

`ifdef MUX_SCAN_CHANGE_ONLY_EN
  logic [W-1:0] m_last [4];
  bit           m_seen [4];
`endif

  mux_scan_seq #(.W(W), .SETTLE_CYCLES(S)) dut (
    .Clk        (clk),
    .Rst_n      (rst_n),
    .Start      (start),
    .Continuous (continuous),
    .ChEn       (chen),
    .Sel        (sel),
    .Yin        (yin),
    .OutValid   (out_valid),
    .OutReady   (out_ready),
    .OutCh      (out_ch),
    .OutData    (out_data),
    .Busy       (busy),
    .ScanDone   (scan_done)
  );

  // Behavioural 4:1 mux between the sources and the sequencer.
  assign yin = d[sel];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes and ScanDone pulses are observed mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        b_ch.push_back(int'(out_ch));
        b_d.push_back(int'(out_data));
        b_t.push_back(cyc);
      end
      if (scan_done) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
`ifdef MUX_SCAN_CHANGE_ONLY_EN
    for (int i = 0; i < 4; i++) begin
      m_seen[i] = 1'b0;
      m_last[i] = '0;
    end
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    continuous = 1'b0;
    out_ready = 1'b1;
    chen = 4'h0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    model_clear();
  endtask

  task automatic start_scan(input logic [3:0] m, input logic rdy, output int k);
    b_ch.delete();
    b_d.delete();
    b_t.delete();
    done_cnt = 0;
    chen = m;
    start = 1'b1;
    out_ready = rdy;
    k = cyc + 1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd);
    for (int i = 0; i < 300 && busy; i++) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rnd) chen = 4'($urandom);
      tick();
    end
    chk("scan_terminates", busy, 0);
    tick();
  endtask

  // Expected beats: enabled channels ascending, each carrying its source value.
  task automatic compare(input logic [3:0] m);
    int e_ch [$];
    int e_d  [$];
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
`ifdef MUX_SCAN_CHANGE_ONLY_EN
        if (m_seen[i] && m_last[i] == d[i]) continue;
        m_seen[i] = 1'b1;
        m_last[i] = d[i];
`endif
        e_ch.push_back(i);
        e_d.push_back(int'(d[i]));
      end
    end
    chk("beat_count", b_ch.size(), e_ch.size());
    for (int i = 0; i < e_ch.size() && i < b_ch.size(); i++) begin
      chk("beat_ch", b_ch[i], e_ch[i]);
      chk("beat_data", b_d[i], e_d[i]);
    end
    chk("scan_done_count", done_cnt, (m != 4'h0) ? 1 : 0);
  endtask

  task automatic chk_timing(input int k);
    for (int i = 0; i < b_t.size(); i++) begin
      chk("beat_time", b_t[i], k + 1 + S + i * (2 + S));
    end
  endtask

  initial begin
    int k;
    logic [1:0]   h_ch;
    logic [W-1:0] h_d;

    rst_n = 1'b0;
    start = 1'b0;
    continuous = 1'b0;
    out_ready = 1'b0;
    chen = 4'h0;
    d[0] = 4'h1; d[1] = 4'h2; d[2] = 4'h3; d[3] = 4'h4;
    model_clear();
    #2;
    chk("rst_sel", sel, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", scan_done, 0);
    do_reset();

    // Full scan, ready always high.
    start_scan(4'b1111, 1'b1, k);
    chk("busy_after_start", busy, 1);
    wait_idle(1'b0);
    compare(4'b1111);
    chk_timing(k);

    // Sparse mask.
    do_reset();
    start_scan(4'b1010, 1'b1, k);
    wait_idle(1'b0);
    compare(4'b1010);
    chk_timing(k);
    chk("sel_kept_last", sel, 3);

    // Back-pressure on the first beat.
    do_reset();
    start_scan(4'b1111, 1'b0, k);
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    chk("bp_valid_seen", out_valid, 1);
    h_ch = out_ch;
    h_d = out_data;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid_hold", out_valid, 1);
      chk("bp_ch_hold", out_ch, h_ch);
      chk("bp_data_hold", out_data, h_d);
      chk("bp_sel_hold", sel, 0);
    end
    wait_idle(1'b0);
    compare(4'b1111);

    // Continuous scanning of a single channel, then mask cleared.
    do_reset();
    continuous = 1'b1;
    start_scan(4'b0001, 1'b1, k);
    repeat (12) tick();
    chen = 4'h0;
    wait_idle(1'b0);
    continuous = 1'b0;
    for (int i = 0; i < b_ch.size(); i++) begin
      chk("cont_ch", b_ch[i], 0);
      chk("cont_data", b_d[i], 1);
    end
`ifdef MUX_SCAN_CHANGE_ONLY_EN
    chk("cont_beats", b_ch.size(), 1);
    chk("cont_scans_ge3", done_cnt >= 3, 1);
`else
    chk("cont_beats_ge3", b_ch.size() >= 3, 1);
    chk("cont_done_eq_beats", done_cnt, b_ch.size());
    for (int i = 1; i < b_t.size(); i++) begin
      chk("cont_spacing", b_t[i] - b_t[i-1], 2 + S);
    end
`endif

    // Start with empty mask is ignored.
    do_reset();
    start_scan(4'b0000, 1'b1, k);
    chk("empty_start_busy", busy, 0);
    repeat (3) tick();
    chk("empty_start_done", done_cnt, 0);

    // Asynchronous reset mid-SEND.
    start_scan(4'b1111, 1'b0, k);
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_sel", sel, 0);
    chk("arst_busy", busy, 0);
    chk("arst_data", out_data, 0);
    tick();
    rst_n = 1'b1;
    model_clear();
    tick();

    // Start while busy is ignored.
    start_scan(4'b0001, 1'b0, k);
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    chen = 4'b1111;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_ch", out_ch, 0);
    wait_idle(1'b0);
    compare(4'b0001);

`ifdef MUX_SCAN_CHANGE_ONLY_EN
    do_reset();
    start_scan(4'b1111, 1'b1, k);
    wait_idle(1'b0);
    compare(4'b1111);
    chk("co_first_beats", b_ch.size(), 4);
    start_scan(4'b1111, 1'b1, k);
    wait_idle(1'b0);
    compare(4'b1111);
    chk("co_static_beats", b_ch.size(), 0);
    d[2] = 4'h9;
    start_scan(4'b1111, 1'b1, k);
    wait_idle(1'b0);
    compare(4'b1111);
    chk("co_change_beats", b_ch.size(), 1);
    if (b_ch.size() > 0) begin
      chk("co_change_ch", b_ch[0], 2);
      chk("co_change_data", b_d[0], 9);
    end
`endif

    // Randomised scans: random sources, masks, back-pressure and mid-scan ChEn noise.
    do_reset();
    for (int n = 0; n < 30; n++) begin
      logic [3:0] m;
      for (int i = 0; i < 4; i++) d[i] = W'($urandom_range(0, 3));
      m = 4'($urandom);
      start_scan(m, 1'($urandom_range(0, 1)), k);
      wait_idle(1'b1);
      compare(m);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
